dmem_bridge: RTL

Bridges the CPU core's single-cycle data port (ALU-result address, write data, read data) to a multi-cycle valid/ready data bus. It sits directly downstream of the core: it consumes the load/store address and store data, stalls the core while the bus transaction is outstanding, and returns load data. It also flags misaligned, erroring and timed-out accesses.

---
 rtl/dmem_bridge_if.sv | 21 ++
 rtl/dmem_bridge.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dmem_bridge_if.sv
// Valid/ready data-bus bundle between the core's memory bridge (master)
// and the memory/peripheral fabric (slave).
interface dmem_bridge_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata, bus_err
  );
endinterface : dmem_bridge_if

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle load/store port to a multi-cycle valid/ready
// bus: stalls the core while a transaction is outstanding and flags errors.
module dmem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          err_clr,
  output logic          err_flag,
  dmem_bridge_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        req;

  assign req = cpu_we | cpu_re;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (cpu_addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately without touching the bus.
            state_d = ST_DONE;
            rdata_d = '0;
            err_set = 1'b1;
          end else begin
            state_d = ST_BUSY;
            addr_d  = {cpu_addr[31:2], 2'b00};
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
            cnt_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        // bus_ready wins over an expiring timeout in the same cycle.
        if (bus.bus_ready) begin
          state_d = ST_DONE;
          rdata_d = (bus.bus_err || we_q) ? '0 : bus.bus_rdata;
          err_set = bus.bus_err;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          rdata_d = '0;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Setting the sticky flag beats a simultaneous clear.
  assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // bus_valid decodes straight from the state register, so an async reset
  // drops it in the same instant.
  assign bus.bus_valid = (state_q == ST_BUSY);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  assign cpu_stall = ((state_q == ST_IDLE) && req) || (state_q == ST_BUSY);
  assign cpu_rdata = rdata_q;
  assign err_flag  = err_q;

endmodule : dmem_bridge
